// File: rtl/dpram_stream_reader.sv
// Streams a burst of consecutive words out of a synchronous dual-port RAM read port
// onto a valid/ready interface, with credit-limited issue so the 4-entry skid FIFO never overflows.
//
// state | meaning
// IDLE  | waiting for a start command
// RUN   | issuing read addresses until the whole burst has been requested
// DRAIN | all reads issued; waiting for the last beat to be accepted
module dpram_stream_reader #(
   parameter int  DBW   = 32,
   parameter int  DEPTH = 1023,
   localparam int ABW   = $clog2(DEPTH),
   localparam int LBW   = $clog2(DEPTH + 1)
) (
   input  logic           iCLK,
   input  logic           iRST_N,
   input  logic           iSTART,
   input  logic [ABW-1:0] iBASE,
   input  logic [LBW-1:0] iLEN,
   output logic           oBUSY,
   output logic           oDONE,
   output logic [ABW-1:0] oRAM_ADDR,
   output logic           oRAM_WR,
   input  logic [DBW-1:0] iRAM_RDATA,
   output logic [DBW-1:0] oDATA,
   output logic           oVALID,
   input  logic           iREADY
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t         state, stateNxt;
   logic [LBW-1:0] issueCnt, beatCnt, lenSat;
   logic [ABW-1:0] ramAddr, addrInc;
   logic           addrVld, capVld;
   logic [2:0]     fifoCnt, occupancy;
   logic [1:0]     wrPtr, rdPtr;
   logic [DBW-1:0] fifoMem [4];
   logic           doneReg, startOk, issue, pop, credit, lastBeat;

   generate
      if (DEPTH < (2 ** LBW) - 1) begin : g_sat
         assign lenSat = (iLEN > LBW'(DEPTH)) ? LBW'(DEPTH) : iLEN;
      end else begin : g_nosat
         assign lenSat = iLEN;
      end
   endgenerate

   // A read occupies a credit from issue until its word leaves the FIFO.
   assign occupancy = fifoCnt + {2'b00, addrVld} + {2'b00, capVld};
   assign credit    = (occupancy < 3'd4);
   assign startOk   = iSTART && (state == IDLE);
   assign pop       = oVALID && iREADY;
   assign lastBeat  = pop && (beatCnt == LBW'(1));
   assign addrInc   = (ramAddr == ABW'(DEPTH - 1)) ? '0 : ramAddr + ABW'(1);

   always_comb begin
      stateNxt = state;
      issue    = 1'b0;
      case (state)
         IDLE: begin
            if (startOk && (lenSat != '0)) begin
               stateNxt = RUN;
               issue    = 1'b1;
            end
         end
         RUN: begin
            issue = (issueCnt != '0) && credit;
            if (issueCnt == '0) stateNxt = DRAIN;
            if (lastBeat)       stateNxt = IDLE;
         end
         DRAIN: begin
            if (lastBeat) stateNxt = IDLE;
         end
         default: stateNxt = IDLE;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state    <= IDLE;
         issueCnt <= '0;
         beatCnt  <= '0;
         ramAddr  <= '0;
         addrVld  <= 1'b0;
         capVld   <= 1'b0;
         doneReg  <= 1'b0;
         wrPtr    <= '0;
         rdPtr    <= '0;
         fifoCnt  <= '0;
      end else begin
         state   <= stateNxt;
         addrVld <= issue;
         capVld  <= addrVld;
         doneReg <= (startOk && (lenSat == '0)) || lastBeat;

         // The first address goes out on the start edge itself, so one read is already counted.
         if (state == IDLE && issue) begin
            issueCnt <= lenSat - LBW'(1);
            beatCnt  <= lenSat;
            ramAddr  <= iBASE;
         end else begin
            if (issue) begin
               issueCnt <= issueCnt - LBW'(1);
               ramAddr  <= addrInc;
            end
            if (pop) beatCnt <= beatCnt - LBW'(1);
         end

         if (capVld) wrPtr <= wrPtr + 2'd1;
         if (pop)    rdPtr <= rdPtr + 2'd1;
         case ({capVld, pop})
            2'b10:   fifoCnt <= fifoCnt + 3'd1;
            2'b01:   fifoCnt <= fifoCnt - 3'd1;
            default: fifoCnt <= fifoCnt;
         endcase
      end
   end

   always_ff @(posedge iCLK) begin
      if (capVld) fifoMem[wrPtr] <= iRAM_RDATA;
   end

   assign oBUSY     = (state != IDLE);
   assign oDONE     = doneReg;
   assign oRAM_ADDR = ramAddr;
   assign oRAM_WR   = 1'b0;
   assign oVALID    = (fifoCnt != 3'd0);
   assign oDATA     = oVALID ? fifoMem[rdPtr] : '0;

endmodule
